// File: rtl/rr_sel_arbiter_pkg.sv
// Shared constants, state encoding and round-robin scan helper for the
// select-index arbiter that feeds the 3-to-8 decoder.
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } win_t;

  // Scans from the highest offset down so the candidate closest to ptr is
  // the last one written and therefore wins.
  function automatic win_t next_winner(input logic [N_REQ-1:0] req,
                                       input logic [SEL_W-1:0] ptr);
    win_t             w;
    logic [SEL_W-1:0] cand;
    w = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        w.found = 1'b1;
        w.idx   = cand;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_sel_arbiter_if.sv
// Request/select bundle between the requesting units (master) and the
// arbiter (slave).
interface rr_sel_arbiter_if;
  import rr_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic [N_REQ-1:0] grant;
  logic             expired;
  logic             busy;

  modport master (
    output req,
    input  sel, sel_valid, grant, expired, busy
  );

  modport slave (
    input  req,
    output sel, sel_valid, grant, expired, busy
  );

endinterface

// File: rtl/rr_sel_arbiter_dec.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module sel_onehot_dec
  import rr_arb_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin owner selection for a shared decoded resource, with a bounded
// hold time and a mandatory one-cycle dead gap between successive owners.
module rr_sel_arbiter
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_sel_arbiter_if.slave bus
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state_q, state_nxt;
  logic [SEL_W-1:0] sel_q, sel_nxt;
  logic [SEL_W-1:0] ptr_q, ptr_nxt;
  logic [7:0]       hcnt_q, hcnt_nxt;
  logic             expired_q, expired_nxt;
  logic             sel_valid_q, sel_valid_nxt;
  logic             busy_q, busy_nxt;
  logic [N_REQ-1:0] grant_w;
  win_t             win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      ptr_q       <= '0;
      hcnt_q      <= '0;
      expired_q   <= 1'b0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      sel_q       <= sel_nxt;
      ptr_q       <= ptr_nxt;
      hcnt_q      <= hcnt_nxt;
      expired_q   <= expired_nxt;
      sel_valid_q <= sel_valid_nxt;
      busy_q      <= busy_nxt;
    end
  end

  // GAP arbitrates with the pointer already advanced past the old owner,
  // so a timed-out requester only returns when the scan reaches it again.
  always_comb begin
    state_nxt   = state_q;
    sel_nxt     = sel_q;
    ptr_nxt     = ptr_q;
    hcnt_nxt    = hcnt_q;
    expired_nxt = 1'b0;
    win         = next_winner(bus.req, ptr_q);
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (win.found) begin
          state_nxt = ST_GRANT;
          sel_nxt   = win.idx;
          hcnt_nxt  = '0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        hcnt_nxt = hcnt_q + 8'd1;
        if (!bus.req[sel_q]) begin
          state_nxt = ST_GAP;
          ptr_nxt   = sel_q + SEL_W'(1);
        end else if (hcnt_q == HOLD_LAST) begin
          state_nxt   = ST_GAP;
          ptr_nxt     = sel_q + SEL_W'(1);
          expired_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Qualifiers are precomputed from the next state so they leave a flop.
  always_comb begin
    sel_valid_nxt = (state_nxt == ST_GRANT);
    busy_nxt      = (state_nxt != ST_IDLE);
  end

  sel_onehot_dec u_dec (
    .sel    (sel_q),
    .en     (sel_valid_q),
    .onehot (grant_w)
  );

  assign bus.sel       = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.grant     = grant_w;
  assign bus.expired   = expired_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed bench for rr_sel_arbiter: default hold of 15 on one instance and
// a short hold of 4 on a second instance for the timeout scenarios.
module tb_rr_sel_arbiter;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  rr_sel_arbiter_if bus15 ();
  rr_sel_arbiter_if bus4 ();

  rr_sel_arbiter #(.MAX_HOLD(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus15)
  );

  rr_sel_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus15.req  = 8'hFF;
    bus4.req   = 8'hFF;
    repeat (3) tick();
    vectors++;
    if ({bus15.sel, bus15.sel_valid, bus15.grant, bus15.expired, bus15.busy} !== 14'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got sel=%0d v=%b g=%h e=%b b=%b want all zero",
               bus15.sel, bus15.sel_valid, bus15.grant, bus15.expired, bus15.busy);
    end
    bus15.req = 8'h00;
    bus4.req  = 8'h00;
    rst_n     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus15.grant !== 8'h00 || bus15.busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL idle_after_reset: got g=%h b=%b want g=00 b=0", bus15.grant, bus15.busy);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_g;
    bus15.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_g = 8'h01 << (k % 8);
      for (int c = 0; c < 15; c++) begin
        tick();
        vectors++;
        if (bus15.grant !== exp_g || bus15.expired !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL rr_hold owner %0d cyc %0d: got g=%h e=%b want g=%h e=0",
                   k % 8, c, bus15.grant, bus15.expired, exp_g);
        end
      end
      tick();
      vectors++;
      if (bus15.grant !== 8'h00 || bus15.expired !== 1'b1 || bus15.busy !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL rr_gap after owner %0d: got g=%h e=%b b=%b want g=00 e=1 b=1",
                 k % 8, bus15.grant, bus15.expired, bus15.busy);
      end
    end
    bus15.req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_single();
    bus15.req = 8'h04;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (bus15.sel !== 3'd2 || bus15.grant !== 8'h04 || bus15.sel_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL single_grant cyc %0d: got sel=%0d g=%h v=%b want sel=2 g=04 v=1",
                 i, bus15.sel, bus15.grant, bus15.sel_valid);
      end
    end
    bus15.req = 8'h00;
    tick();
    vectors++;
    if (bus15.grant !== 8'h00 || bus15.sel_valid !== 1'b0 || bus15.busy !== 1'b1 || bus15.expired !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_gap: got g=%h v=%b b=%b e=%b want g=00 v=0 b=1 e=0",
               bus15.grant, bus15.sel_valid, bus15.busy, bus15.expired);
    end
    tick();
    vectors++;
    if (bus15.busy !== 1'b0 || bus15.grant !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL single_idle: got b=%b g=%h want b=0 g=00", bus15.busy, bus15.grant);
    end
  endtask

  task automatic test_wrap();
    bus15.req = 8'h40;
    tick();
    vectors++;
    if (bus15.sel !== 3'd6 || bus15.grant !== 8'h40) begin
      miscompares++;
      $display("[TB] FAIL wrap_owner6: got sel=%0d g=%h want sel=6 g=40", bus15.sel, bus15.grant);
    end
    bus15.req = 8'h01;
    tick();
    vectors++;
    if (bus15.grant !== 8'h00 || bus15.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL wrap_gap1: got g=%h b=%b want g=00 b=1", bus15.grant, bus15.busy);
    end
    bus15.req = 8'h41;
    tick();
    vectors++;
    if (bus15.sel !== 3'd0 || bus15.grant !== 8'h01) begin
      miscompares++;
      $display("[TB] FAIL wrap_to_0: got sel=%0d g=%h want sel=0 g=01", bus15.sel, bus15.grant);
    end
    bus15.req = 8'h40;
    tick();
    vectors++;
    if (bus15.grant !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL wrap_gap2: got g=%h want g=00", bus15.grant);
    end
    bus15.req = 8'h41;
    tick();
    vectors++;
    if (bus15.sel !== 3'd6 || bus15.grant !== 8'h40) begin
      miscompares++;
      $display("[TB] FAIL wrap_to_6: got sel=%0d g=%h want sel=6 g=40", bus15.sel, bus15.grant);
    end
    bus15.req = 8'h00;
    tick();
    tick();
    vectors++;
    if (bus15.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wrap_idle: got b=%b want b=0", bus15.busy);
    end
  endtask

  task automatic test_async_reset();
    bus15.req = 8'h10;
    tick();
    vectors++;
    if (bus15.grant !== 8'h10) begin
      miscompares++;
      $display("[TB] FAIL async_pre_grant: got g=%h want g=10", bus15.grant);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus15.grant !== 8'h00 || bus15.sel_valid !== 1'b0 || bus15.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_drop: got g=%h v=%b b=%b want g=00 v=0 b=0",
               bus15.grant, bus15.sel_valid, bus15.busy);
    end
    bus15.req = 8'hxx;
    tick();
    rst_n     = 1'b1;
    bus15.req = 8'h11;
    tick();
    vectors++;
    if (bus15.sel !== 3'd0 || bus15.grant !== 8'h01) begin
      miscompares++;
      $display("[TB] FAIL async_ptr_reset: got sel=%0d g=%h want sel=0 g=01", bus15.sel, bus15.grant);
    end
    bus15.req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    bus4.req = 8'h80;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        vectors++;
        if (bus4.grant !== 8'h80 || bus4.expired !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL to_hold p%0d c%0d: got g=%h e=%b want g=80 e=0",
                   p, c, bus4.grant, bus4.expired);
        end
      end
      tick();
      vectors++;
      if (bus4.grant !== 8'h00 || bus4.expired !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL to_expire p%0d: got g=%h e=%b want g=00 e=1", p, bus4.grant, bus4.expired);
      end
    end
    // Release on the very cycle the timeout would fire: release wins.
    repeat (4) tick();
    bus4.req = 8'h00;
    tick();
    vectors++;
    if (bus4.grant !== 8'h00 || bus4.expired !== 1'b0 || bus4.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL to_release_wins: got g=%h e=%b b=%b want g=00 e=0 b=1",
               bus4.grant, bus4.expired, bus4.busy);
    end
    tick();
    vectors++;
    if (bus4.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL to_idle: got b=%b want b=0", bus4.busy);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_round_robin();
    test_single();
    test_wrap();
    test_async_reset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
